shift_reg_univ: RTL

- Parametrised universal shift register; successor to the fixed 4-bit load/serial-shift register.
- Adds generic width, four shift modes, a registered serial-out bit and synchronous reset.
- Adds a counted burst engine: a single start performs N shifts autonomously, with busy/done handshake.
- Used as a building block wherever datapaths need parallel load plus serial or rotating movement.

---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/shift_reg_univ_shift_step.sv | 40 ++++
 rtl/shift_reg_univ.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_*  : two-bit step-mode encodings used on the mode input and the
//             latched burst direction.
//   state_t : burst controller state (IDLE / BUSY).
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_ROR  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/shift_reg_univ_shift_step.sv
// shift_step: combinational single-step function of the shift register.
// Ports:
//   q       in   WIDTH  current register contents
//   w       in   1      serial input bit
//   mode    in   2      hold / shift right / shift left / rotate right
//   q_next  out  WIDTH  contents after one step
//   out_bit out  1      bit leaving the register (0 for hold; caller keeps sout)
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             w,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_next  = {w, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], w};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register with counted bursts.
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous reset, active-high
//   L       in   1      parallel load enable (aborts a running burst)
//   R       in   WIDTH  parallel load data
//   w       in   1      serial input bit
//   mode    in   2      00 hold, 01 shift right, 10 shift left, 11 rotate right
//   start   in   1      begin a burst (sampled only when idle)
//   amount  in   AMT_W  number of steps in the burst
//   Q       out  WIDTH  register contents
//   sout    out  1      last bit shifted/rotated out (registered)
//   busy    out  1      burst in progress
//   done    out  1      one-cycle pulse after the last burst step
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             L,
    input  logic [WIDTH-1:0] R,
    input  logic             w,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [1:0]       dir;
    logic [AMT_W-1:0] cnt;

    logic [1:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // One step unit serves both paths: the latched direction while bursting,
    // the live mode input otherwise.
    assign step_mode = (state == BUSY) ? dir : mode;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (Q),
        .w       (w),
        .mode    (step_mode),
        .q_next  (step_q),
        .out_bit (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Q     <= '0;
            sout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            dir   <= MODE_HOLD;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (L) begin
                Q     <= R;
                busy  <= 1'b0;
                state <= IDLE;
                cnt   <= '0;
            end else if (state == BUSY) begin
                Q <= step_q;
                if (dir != MODE_HOLD)
                    sout <= step_out;
                cnt <= cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end else if (start) begin
                // Accept edge: data is untouched, the burst steps begin next edge.
                if (amount != '0) begin
                    dir   <= mode;
                    cnt   <= amount;
                    busy  <= 1'b1;
                    state <= BUSY;
                end else begin
                    done <= 1'b1;
                end
            end else begin
                Q <= step_q;
                if (mode != MODE_HOLD)
                    sout <= step_out;
            end
        end
    end

endmodule
